// File: rtl/fwrd_bypass_unit_pkg.sv
// Shared types and constants for the forwarding/bypass unit.
package fwrd_bypass_unit_pkg;

    localparam int unsigned PREG_W = 6;
    localparam int unsigned XLEN   = 32;

    // One held execute result.
    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] preg;
        logic [XLEN-1:0]   val;
    } fwrd_entry_t;

    // Source selected by a lookup.
    typedef enum logic [1:0] {
        FWRD_MUX_NONE,
        FWRD_MUX_LIVE,
        FWRD_MUX_BUF
    } fwrd_mux;

endpackage

// File: rtl/fwrd_bypass_unit_if.sv
// Result-capture and register-read lookup bundle for the bypass unit.
interface fwrd_bypass_unit_if
    import fwrd_bypass_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) ();

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic              flush;
    logic              res_valid;
    logic [PREG_W-1:0] res_preg;
    logic [XLEN-1:0]   res_val;
    logic [PREG_W-1:0] src1_reg;
    logic [PREG_W-1:0] src2_reg;
    logic              src1_fwrd_hit;
    logic [XLEN-1:0]   src1_val;
    logic              src2_fwrd_hit;
    logic [XLEN-1:0]   src2_val;
    logic [OCC_W-1:0]  occupancy;

    // Pipeline side: drives results and lookup indices.
    modport master (
        output flush, res_valid, res_preg, res_val, src1_reg, src2_reg,
        input  src1_fwrd_hit, src1_val, src2_fwrd_hit, src2_val, occupancy
    );

    // Bypass unit side.
    modport slave (
        input  flush, res_valid, res_preg, res_val, src1_reg, src2_reg,
        output src1_fwrd_hit, src1_val, src2_fwrd_hit, src2_val, occupancy
    );

endinterface

// File: rtl/fwrd_bypass_unit_lookup.sv
// Youngest-first priority match of one source register against the
// live result and the held entries.
module fwrd_bypass_unit_lookup
    import fwrd_bypass_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                    i_live_valid,
    input  logic [PREG_W-1:0]       i_live_preg,
    input  logic [XLEN-1:0]         i_live_val,
    input  fwrd_entry_t [DEPTH-1:0] i_entries,
    input  logic [PREG_W-1:0]       i_src_reg,
    output logic                    o_hit_c,
    output logic [XLEN-1:0]         o_val_c
);

    fwrd_mux         w_sel;
    logic [XLEN-1:0] w_buf_val;

    // Scan oldest to youngest so younger matches overwrite; live input wins last.
    always_comb begin
        w_sel     = FWRD_MUX_NONE;
        w_buf_val = '0;
        if (i_src_reg != '0) begin
            for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
                if (i_entries[i].valid && (i_entries[i].preg == i_src_reg)) begin
                    w_sel     = FWRD_MUX_BUF;
                    w_buf_val = i_entries[i].val;
                end
            end
            if (i_live_valid && (i_live_preg == i_src_reg)) begin
                w_sel = FWRD_MUX_LIVE;
            end
        end
    end

    // Drive hit/value from the selected source; misses return zero.
    always_comb begin
        o_hit_c = 1'b0;
        o_val_c = '0;
        case (w_sel)
            FWRD_MUX_LIVE: begin
                o_hit_c = 1'b1;
                o_val_c = i_live_val;
            end
            FWRD_MUX_BUF: begin
                o_hit_c = 1'b1;
                o_val_c = w_buf_val;
            end
            default: begin
                o_hit_c = 1'b0;
                o_val_c = '0;
            end
        endcase
    end

endmodule

// File: rtl/fwrd_bypass_unit.sv
// Age-ordered bypass buffer holding execute results until the register
// file write becomes visible, with two zero-latency source lookups.
module fwrd_bypass_unit
    import fwrd_bypass_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    fwrd_bypass_unit_if.slave  bus
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    fwrd_entry_t [DEPTH-1:0] r_entries;
    fwrd_entry_t [DEPTH-1:0] w_next;
    logic [OCC_W-1:0]        r_occ;
    logic [OCC_W-1:0]        w_next_occ;
    logic                    w_live_valid;

    // A flushed result must not be forwarded in its own cycle either.
    assign w_live_valid = bus.res_valid && !bus.flush;

    // Unconditional age shift; the oldest entry falls off into the register file.
    always_comb begin
        w_next = '0;
        if (!bus.flush) begin
            for (int i = int'(DEPTH) - 1; i > 0; i--) begin
                w_next[i] = r_entries[i-1];
            end
            w_next[0].valid = bus.res_valid && (bus.res_preg != '0);
            w_next[0].preg  = bus.res_preg;
            w_next[0].val   = bus.res_val;
        end
    end

    // Popcount of the next-state valid bits, so occupancy is a plain register.
    always_comb begin
        w_next_occ = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_next_occ = w_next_occ + OCC_W'(w_next[i].valid);
        end
    end

    // Buffer and occupancy state; reset clears every field.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_entries <= '0;
            r_occ     <= '0;
        end else begin
            r_entries <= w_next;
            r_occ     <= w_next_occ;
        end
    end

    assign bus.occupancy = r_occ;

    fwrd_bypass_unit_lookup #(.DEPTH(DEPTH)) u_lookup_src1 (
        .i_live_valid (w_live_valid),
        .i_live_preg  (bus.res_preg),
        .i_live_val   (bus.res_val),
        .i_entries    (r_entries),
        .i_src_reg    (bus.src1_reg),
        .o_hit_c      (bus.src1_fwrd_hit),
        .o_val_c      (bus.src1_val)
    );

    fwrd_bypass_unit_lookup #(.DEPTH(DEPTH)) u_lookup_src2 (
        .i_live_valid (w_live_valid),
        .i_live_preg  (bus.res_preg),
        .i_live_val   (bus.res_val),
        .i_entries    (r_entries),
        .i_src_reg    (bus.src2_reg),
        .o_hit_c      (bus.src2_fwrd_hit),
        .o_val_c      (bus.src2_val)
    );

endmodule

// File: doc/fwrd_bypass_unit.md
Name: fwrd_bypass_unit

Overview:
- Responder side of the fwrd_reg_read_if lookup used by the register-read stage.
- Captures execute-stage results and holds them in an age-ordered bypass buffer until the physical register file write is visible to readers.
- Answers two source-register lookups per cycle with hit flags and values.
- Sits between the execute/writeback result bus and the register-read stage.

Parameters:
- PREG_W, 6: physical register index width.
- DEPTH, 2: number of cycles a result stays forwardable. Equals the cycles from result-bus valid until the register file read returns it. Legal values are 1..4.
- XLEN, 32: data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  pipeline flush (mispredict); discards all held results.
- res_valid  in  1  execute result valid this cycle.
- res_preg  in  PREG_W  destination physical register of the result.
- res_val  in  XLEN  result value.
- src1_reg  in  PREG_W  lookup index, source 1.
- src2_reg  in  PREG_W  lookup index, source 2.
- src1_fwrd_hit  out  1  source 1 matched a forwardable result.
- src1_val  out  XLEN  forwarded value for source 1.
- src2_fwrd_hit  out  1  source 2 matched a forwardable result.
- src2_val  out  XLEN  forwarded value for source 2.
- occupancy  out  $clog2(DEPTH+1)  count of valid buffer entries (debug/perf).

Behaviour:
- Storage: DEPTH entries e[0..DEPTH-1], each holding {valid, preg, val}. e[0] is the youngest; e[i] holds the result accepted i+1 cycles ago.
- Every clock edge, when not in reset and not flushing:
  - e[i+1] <= e[i] for i = 0..DEPTH-2.
  - e[0] <= {res_valid && res_preg != 0, res_preg, res_val}.
  - e[DEPTH-1] is dropped; its value is in the register file by then.
- The shift is unconditional. No stall input exists: aging tracks fixed register-file write latency, not pipeline progress.
- flush = 1: all entries become invalid on that edge. A res_valid presented in the same cycle is also discarded. Flush is a no-op when already empty.
- Reset: all entries invalid. preg and val fields are cleared to 0. Reset has priority over flush.
- Lookup is purely combinational, with zero-cycle latency, so the register-read stage can mux in the same cycle. Candidates are checked in priority order, youngest first:
  1. Live input: res_valid && !flush && res_preg == srcN_reg.
  2. e[0].
  3. e[1], and so on to e[DEPTH-1].
- The first match sets srcN_fwrd_hit = 1 and srcN_val to that value. A younger write to the same preg always shadows older entries.
- preg 0 is the hardwired zero register. srcN_reg == 0 never hits, even if an entry with preg 0 existed (none can be stored).
- On a miss: srcN_fwrd_hit = 0 and srcN_val = 0. Outputs are never X.
- During a flush cycle, outputs still reflect entries held before the edge. The live-input path is masked.
- src1 and src2 lookups are independent and may hit the same entry.
- occupancy = popcount of entry valid bits, registered state only.
- Outputs after reset: both hit flags 0, both values 0, occupancy 0.

Decomposition:
- Shared package: a fwrd_entry_t struct {valid, preg, val} and the PREG_W/XLEN constants.
- Reuse the existing fwrd_mux enum; do not redefine it.
- One sub-module is natural: fwrd_lookup, a combinational priority match for one source, instantiated twice.
- Buffer shift and flush logic live in the top level.

Test Plan:
- Reset, then look up src1 = 5 with an empty buffer -> hit 0, val 0, occupancy 0.
- res {valid, preg 7, 0xAAAA_0001}, same-cycle lookup src1 = 7 -> hit 1, val 0xAAAA_0001. Src1 stays hit on each of the next DEPTH (2) cycles, then misses on cycle 3.
- res preg 9 = 0x11 at t0 and preg 9 = 0x22 at t1, lookup at t1 -> val 0x22 (live input). Lookup at t2 -> 0x22 (e[0] shadows e[1]).
- res preg 0 = 0xFFFF_FFFF, lookup src1 = src2 = 0 -> both hit 0 and val 0. Occupancy unchanged next cycle.
- Fill the buffer with pregs 3 and 4, then assert flush with res preg 3 = 0x55 -> next cycle lookups for 3 and 4 miss and occupancy = 0. During the flush cycle, src 3 returns the older buffered value, not 0x55.
- Assert rst mid-stream with two valid entries -> next cycle all lookups miss and occupancy = 0. The first post-reset result is forwarded normally.
